// File: rtl/cpu_wb_merge_pkg.sv
// Shared types for the writeback merge path: one pending register write.
package cpu_wb_merge_pkg;
  localparam int REG_W        = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int REG_ID_W     = $clog2(NUM_REGS_DEF);

  typedef struct packed {
    logic [REG_ID_W-1:0] rd_id;
    logic [REG_W-1:0]    value;
  } wb_entry_t;
endpackage

// File: rtl/cpu_wb_fifo.sv
// In-order FIFO of displaced writebacks with a youngest-first forwarding lookup.
module cpu_wb_fifo
  import cpu_wb_merge_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push_i,
  input  wb_entry_t           push_entry_i,
  input  logic                pop_i,
  output wb_entry_t           head_o,
  output logic [CW-1:0]       count_o,
  output logic                full_o,
  output logic                empty_o,
  input  logic [REG_ID_W-1:0] lookup_id_i,
  output logic                lookup_hit_o,
  output logic [REG_W-1:0]    lookup_value_o
);
  wb_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push;

  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign head_o   = mem_q[rd_ptr_q];
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push  = push_i && (!full_o || pop_i);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)   rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !pop_i)      count_d = count_q + CW'(1);
    else if (!do_push && pop_i) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  // Walk oldest to youngest so a later (younger) match overrides an earlier one.
  always_comb begin
    logic [PW-1:0] idx;
    lookup_hit_o   = 1'b0;
    lookup_value_o = '0;
    idx            = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (mem_q[idx].rd_id == lookup_id_i)) begin
        lookup_hit_o   = 1'b1;
        lookup_value_o = mem_q[idx].value;
      end
    end
  end
endmodule

// File: rtl/cpu_wb_merge.sv
// Merges multiplier writeback with the normal writeback stream onto one
// register-bank write port; the multiplier always wins, displaced writes queue.
module cpu_wb_merge
  import cpu_wb_merge_pkg::*;
#(
  parameter int REG_WIDTH  = REG_W,
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0] wb_rd_id,
  input  logic [REG_WIDTH-1:0]        wb_value,
  input  logic                        mul_valid,
  input  logic [$clog2(NUM_REGS)-1:0] mul_rd_id,
  input  logic [REG_WIDTH-1:0]        mul_value,
  output logic                        rf_we,
  output logic [$clog2(NUM_REGS)-1:0] rf_rd_id,
  output logic [REG_WIDTH-1:0]        rf_data,
  input  logic [$clog2(NUM_REGS)-1:0] lookup_id,
  output logic                        lookup_hit,
  output logic [REG_WIDTH-1:0]        lookup_value,
  output logic                        stall,
  output logic                        overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t     wb_entry, mul_entry, head, sel_entry;
  logic          sel_valid, push, pop, drop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] count, next_count;

  logic                        rf_we_q, rf_we_d;
  logic [$clog2(NUM_REGS)-1:0] rf_rd_id_q, rf_rd_id_d;
  logic [REG_WIDTH-1:0]        rf_data_q, rf_data_d;
  logic                        stall_q, stall_d;
  logic                        overflow_q, overflow_d;

  assign wb_entry  = '{rd_id: wb_rd_id,  value: wb_value};
  assign mul_entry = '{rd_id: mul_rd_id, value: mul_value};

  cpu_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock          (clock),
    .reset          (reset),
    .push_i         (push),
    .push_entry_i   (wb_entry),
    .pop_i          (pop),
    .head_o         (head),
    .count_o        (count),
    .full_o         (fifo_full),
    .empty_o        (fifo_empty),
    .lookup_id_i    (lookup_id),
    .lookup_hit_o   (lookup_hit),
    .lookup_value_o (lookup_value)
  );

  // Once anything is queued, normal writebacks must go through the FIFO to stay in order.
  always_comb begin
    sel_valid = 1'b0;
    sel_entry = wb_entry;
    push      = 1'b0;
    pop       = 1'b0;
    if (mul_valid) begin
      sel_valid = 1'b1;
      sel_entry = mul_entry;
      push      = wb_valid;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_entry = head;
      pop       = 1'b1;
      push      = wb_valid;
    end else if (wb_valid) begin
      sel_valid = 1'b1;
    end
  end

  always_comb begin
    drop       = push && fifo_full && !pop;
    next_count = count;
    if (push && !drop && !pop)  next_count = count + CW'(1);
    else if (pop && !push)      next_count = count - CW'(1);
    rf_we_d    = sel_valid;
    rf_rd_id_d = sel_valid ? sel_entry.rd_id : rf_rd_id_q;
    rf_data_d  = sel_valid ? sel_entry.value : rf_data_q;
    stall_d    = (next_count >= CW'(FIFO_DEPTH - 1));
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_rd_id_q <= '0;
      rf_data_q  <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_id_q <= rf_rd_id_d;
      rf_data_q  <= rf_data_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd_id = rf_rd_id_q;
  assign rf_data  = rf_data_q;
  assign stall    = stall_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_cpu_wb_merge.sv
// Directed bench for cpu_wb_merge: arbitration, queueing, forwarding, overflow, reset.
module tb_cpu_wb_merge;
  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid, mul_valid;
  logic [4:0]  wb_rd_id, mul_rd_id, lookup_id;
  logic [31:0] wb_value, mul_value;
  logic        rf_we, lookup_hit, stall, overflow;
  logic [4:0]  rf_rd_id;
  logic [31:0] rf_data, lookup_value;

  int checks   = 0;
  int failures = 0;

  cpu_wb_merge dut (
    .clock        (clock),
    .reset        (reset),
    .wb_valid     (wb_valid),
    .wb_rd_id     (wb_rd_id),
    .wb_value     (wb_value),
    .mul_valid    (mul_valid),
    .mul_rd_id    (mul_rd_id),
    .mul_value    (mul_value),
    .rf_we        (rf_we),
    .rf_rd_id     (rf_rd_id),
    .rf_data      (rf_data),
    .lookup_id    (lookup_id),
    .lookup_hit   (lookup_hit),
    .lookup_value (lookup_value),
    .stall        (stall),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [4:0] mid, input logic [31:0] mval,
                       input logic wv, input logic [4:0] wid, input logic [31:0] wval);
    mul_valid = mv; mul_rd_id = mid; mul_value = mval;
    wb_valid  = wv; wb_rd_id  = wid; wb_value  = wval;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] id, input logic [31:0] d);
    chk({tag, "_we"}, 64'(rf_we), 64'(we));
    chk({tag, "_id"}, 64'(rf_rd_id), 64'(id));
    chk({tag, "_data"}, 64'(rf_data), 64'(d));
  endtask

  initial begin
    reset = 1'b1;
    idle();
    lookup_id = 5'd0;
    #12;
    chk_rf("reset", 1'b0, 5'd0, 32'h0);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_ovf", 64'(overflow), 64'd0);
    reset = 1'b0;
    step();

    // Direct write when nothing is queued.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h11);
    step();
    chk_rf("direct", 1'b1, 5'd5, 32'h11);
    lookup_id = 5'd5; idle(); #1;
    chk("direct_nohit", 64'(lookup_hit), 64'd0);
    step();
    chk_rf("direct_hold", 1'b0, 5'd5, 32'h11);

    // Mul wins, wb parked and forwarded, then drained.
    drive(1'b1, 5'd3, 32'h30, 1'b1, 5'd4, 32'h40);
    step();
    chk_rf("mulwin", 1'b1, 5'd3, 32'h30);
    idle(); lookup_id = 5'd4; #1;
    chk("fwd_hit", 64'(lookup_hit), 64'd1);
    chk("fwd_val", 64'(lookup_value), 64'h40);
    step();
    chk_rf("drain_r4", 1'b1, 5'd4, 32'h40);
    chk("drain_r4_nohit", 64'(lookup_hit), 64'd0);
    step();
    chk("idle_we", 64'(rf_we), 64'd0);

    // Four mul+wb cycles; stall once count reaches 3, in-order drain.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 5'(10 + k), 32'(32'h100 + k), 1'b1, 5'(k), 32'(k));
      step();
      chk_rf($sformatf("mulq%0d", k), 1'b1, 5'(10 + k), 32'(32'h100 + k));
      chk($sformatf("stall_fill%0d", k), 64'(stall), (k >= 3) ? 64'd1 : 64'd0);
    end
    idle();
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_rf($sformatf("order%0d", k), 1'b1, 5'(k), 32'(k));
      chk($sformatf("stall_drain%0d", k), 64'(stall), (k == 1) ? 64'd1 : 64'd0);
    end
    chk("order_ovf", 64'(overflow), 64'd0);

    // Fill to depth, then overflow drops r7.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'd20, 32'(32'h200 + k), 1'b1, 5'(8 + k), 32'(32'h80 + k));
      step();
    end
    chk("full_ovf0", 64'(overflow), 64'd0);
    drive(1'b1, 5'd21, 32'h210, 1'b1, 5'd7, 32'h77);
    step();
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_stall", 64'(stall), 64'd1);
    idle(); lookup_id = 5'd7; #1;
    chk("ovf_r7_miss", 64'(lookup_hit), 64'd0);
    // Push and pop together while full keeps the count at depth.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC0);
    step();
    chk_rf("fullpp", 1'b1, 5'd8, 32'h80);
    chk("fullpp_stall", 64'(stall), 64'd1);
    idle(); lookup_id = 5'd12; #1;
    chk("fullpp_hit", 64'(lookup_hit), 64'd1);
    chk("fullpp_val", 64'(lookup_value), 64'hC0);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k < 4) chk_rf($sformatf("fulldrain%0d", k), 1'b1, 5'(8 + k), 32'(32'h80 + k));
      else       chk_rf("fulldrain4", 1'b1, 5'd12, 32'hC0);
    end
    chk("ovf_sticky", 64'(overflow), 64'd1);
    step();
    chk("ovf_sticky2", 64'(overflow), 64'd1);
    chk("postdrain_we", 64'(rf_we), 64'd0);

    // Same id twice: lookup returns the younger value, drain keeps order.
    drive(1'b1, 5'd30, 32'h1, 1'b1, 5'd2, 32'hA);
    step();
    drive(1'b1, 5'd31, 32'h2, 1'b1, 5'd2, 32'hB);
    step();
    idle(); lookup_id = 5'd2; #1;
    chk("young_hit", 64'(lookup_hit), 64'd1);
    chk("young_val", 64'(lookup_value), 64'hB);
    step();
    chk_rf("dup_a", 1'b1, 5'd2, 32'hA);
    chk("young_val2", 64'(lookup_value), 64'hB);
    step();
    chk_rf("dup_b", 1'b1, 5'd2, 32'hB);
    chk("dup_miss", 64'(lookup_hit), 64'd0);
    chk("dup_miss_val", 64'(lookup_value), 64'd0);
    step();

    // Async reset mid-cycle with two entries pending.
    drive(1'b1, 5'd25, 32'h55, 1'b1, 5'd20, 32'hE0);
    step();
    drive(1'b1, 5'd26, 32'h66, 1'b1, 5'd21, 32'hE1);
    step();
    idle(); lookup_id = 5'd20;
    #2 reset = 1'b1;
    #1;
    chk_rf("async_rst", 1'b0, 5'd0, 32'h0);
    chk("async_rst_stall", 64'(stall), 64'd0);
    chk("async_rst_ovf", 64'(overflow), 64'd0);
    chk("async_rst_hit", 64'(lookup_hit), 64'd0);
    #1 reset = 1'b0;
    step();
    chk("postrst_we", 64'(rf_we), 64'd0);
    chk("postrst_hit", 64'(lookup_hit), 64'd0);
    step();
    chk("postrst_we2", 64'(rf_we), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_wb_merge.md
Name: cpu_wb_merge

Overview:
- Receiving end of the multiplier writeback path.
- Merges the fixed-latency multiplier writeback (tail of the MUL pipeline) with the normal commit/writeback stream onto the register bank's single write port.
- Neither source can stall, so the multiplier always wins the port. A displaced normal writeback is parked in a small in-order FIFO, drained on idle cycles, and exposed for forwarding.

Parameters:
REG_WIDTH, 32, data width of a register
NUM_REGS, 32, register count; id width = $clog2(NUM_REGS)
FIFO_DEPTH, 4, pending-writeback entries (power of two, >=2)

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-high
wb_valid  in  1  normal writeback request this cycle
wb_rd_id  in  $clog2(NUM_REGS)  destination register of normal writeback
wb_value  in  REG_WIDTH  data of normal writeback
mul_valid  in  1  multiplier writeback (writeback_mul) request this cycle
mul_rd_id  in  $clog2(NUM_REGS)  destination of multiplier writeback
mul_value  in  REG_WIDTH  multiplier result
rf_we  out  1  register bank write enable (registered)
rf_rd_id  out  $clog2(NUM_REGS)  register bank write address (registered)
rf_data  out  REG_WIDTH  register bank write data (registered)
lookup_id  in  $clog2(NUM_REGS)  forwarding query id
lookup_hit  out  1  a pending FIFO entry targets lookup_id (combinational)
lookup_value  out  REG_WIDTH  value of youngest matching pending entry; 0 on miss
stall  out  1  upstream must hold new writebacks (registered)
overflow  out  1  sticky error: a writeback was dropped

Behaviour:
- Reset (async, active-high): rf_we=0, rf_rd_id=0, rf_data=0, stall=0, overflow=0, FIFO count=0, pointers=0. Reset mid-drain discards all pending entries.
- Latency: a write selected in cycle t appears on rf_* at t+1 for exactly one cycle. rf_we=0 when nothing is selected; rf_rd_id/rf_data then hold their previous value.
- Port selection per cycle, in priority order:
  - mul_valid=1: write the mul entry. If wb_valid, push wb into the FIFO.
  - mul_valid=0, FIFO non-empty: pop the head and write it. If wb_valid, push wb. Simultaneous push and pop is legal, including when full; count is unchanged.
  - mul_valid=0, FIFO empty, wb_valid=1: write wb directly; the FIFO is untouched.
  - Otherwise: rf_we=0 next cycle.
- Ordering: once the FIFO is non-empty, every normal writeback goes through it, so normal writebacks retire in program order. Mul vs. normal WAW ordering is guaranteed by the hazard unit and is not checked here.
- Full: a push with count==FIFO_DEPTH and no pop in the same cycle drops the entry and sets overflow. overflow is cleared only by reset.
- stall: registered, next value = (next count >= FIFO_DEPTH-1).
- Lookup: scans the valid entries from youngest to oldest and returns the first rd_id match. It does not see the entry currently on rf_*, nor same-cycle inputs.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package: wb_entry_t typedef (rd_id, value); REG_ID_W constant.
- One sub-module, cpu_wb_fifo: a parameterised sync FIFO with push/pop/count and a youngest-first CAM lookup. Same clock and async reset.
- cpu_wb_merge keeps the arbitration, output registers, stall and overflow logic.

Test Plan:
- Reset asserted asynchronously mid-cycle with 2 entries pending -> all outputs 0 immediately; after release, lookup_hit=0 and nothing drains.
- wb_valid only (r5=0x11) at t0 -> rf_we=1, rf_rd_id=5, rf_data=0x11 at t1; FIFO count stays 0.
- mul_valid (r3=0x30) and wb_valid (r4=0x40) at t0, idle at t1 -> t1 writes r3=0x30; lookup_id=4 at t1 gives hit, 0x40; t2 writes r4=0x40.
- mul_valid for 4 consecutive cycles, each with a wb (r1..r4=1..4), then idle -> stall rises once count reaches 3; entries drain r1..r4 in order on the next 4 cycles.
- FIFO full (DEPTH=4), further mul+wb (r7=0x77) -> entry dropped, overflow=1 and sticky; lookup_id=7 misses.
- FIFO holds r2=0xA (older) and r2=0xB (younger) -> lookup_id=2 returns 0xB; drain writes 0xA then 0xB.
